// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM port arbiter.
package dram_arb_pkg;

    localparam int unsigned CTRL_W   = 3;
    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned STARVE_W = 4;

    localparam logic [CTRL_W-1:0] CTRL_NONE     = 3'b000;
    localparam logic [CTRL_W-1:0] IF_FETCH_CTRL = 3'b010;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2,
        RESP     = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] rd_ctrl;
        logic [CTRL_W-1:0] wr_ctrl;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } dram_cmd_t;

    function automatic logic ctrl_active(input logic [CTRL_W-1:0] rd, input logic [CTRL_W-1:0] wr);
        return (rd != CTRL_NONE) || (wr != CTRL_NONE);
    endfunction

endpackage

// File: rtl/dram_arb_watchdog.sv
// Busy-cycle counter; expired_c flags the LIMIT-th busy cycle without completion.
module dram_arb_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic busy_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        expired_c = busy_i && (cnt_q == CNT_W'(LIMIT - 1));
        if (clear_i) begin
            cnt_d = '0;
        end else if (busy_i && !expired_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one DRAM port between fetch and data access; MEM priority with IF starvation limit.
// Optional busy watchdog enabled by defining DRAM_ARB_TIMEOUT_EN.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned IF_STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [CTRL_W-1:0] mem_rd_ctrl,
    input  logic [CTRL_W-1:0] mem_wr_ctrl,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic [CTRL_W-1:0] dram_rd_ctrl,
    output logic [CTRL_W-1:0] dram_wr_ctrl,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_din,
    input  logic [DATA_W-1:0] dram_dout,
    input  logic              dram_done
);

    arb_state_t            state_q, state_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    dram_cmd_t             cmd_q, cmd_d;
    logic                  if_ready_q, if_ready_d;
    logic                  mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]     mem_rdata_q, mem_rdata_d;
    logic                  if_err_q, if_err_d;
    logic                  mem_err_q, mem_err_d;
    logic                  mem_valid_c;
    logic                  starved_c;
    logic                  grant_c;
    logic                  timeout_c;

    assign mem_valid_c = mem_req && ctrl_active(mem_rd_ctrl, mem_wr_ctrl);
    assign starved_c   = (starve_q == STARVE_W'(IF_STARVE_LIMIT));

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        cmd_d       = cmd_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_err_d    = if_err_q;
        mem_err_d   = mem_err_q;
        grant_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_valid_c && !(if_req && starved_c)) begin
                    state_d       = BUSY_MEM;
                    grant_c       = 1'b1;
                    cmd_d.rd_ctrl = mem_rd_ctrl;
                    cmd_d.wr_ctrl = mem_wr_ctrl;
                    cmd_d.addr    = mem_addr;
                    cmd_d.din     = mem_wdata;
                    if (if_req && !starved_c) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (if_req) begin
                    state_d       = BUSY_IF;
                    grant_c       = 1'b1;
                    starve_d      = '0;
                    cmd_d.rd_ctrl = IF_FETCH_CTRL;
                    cmd_d.wr_ctrl = CTRL_NONE;
                    cmd_d.addr    = if_addr;
                    cmd_d.din     = '0;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (dram_done || timeout_c) begin
                    state_d = RESP;
                    cmd_d   = '0;
                    if (state_q == BUSY_IF) begin
                        if_ready_d = 1'b1;
                        if_err_d   = !dram_done;
                        if_rdata_d = dram_done ? dram_dout : '0;
                    end else begin
                        mem_ready_d = 1'b1;
                        mem_err_d   = !dram_done;
                        // Write-only completions keep the previous load data.
                        if (!dram_done) begin
                            mem_rdata_d = '0;
                        end else if (cmd_q.rd_ctrl != CTRL_NONE) begin
                            mem_rdata_d = dram_dout;
                        end
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef DRAM_ARB_TIMEOUT_EN
    logic busy_c;
    assign busy_c = (state_q == BUSY_IF) || (state_q == BUSY_MEM);

    dram_arb_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (grant_c),
        .busy_i   (busy_c),
        .expired_c(timeout_c)
    );

    assign if_err  = if_err_q;
    assign mem_err = mem_err_q;
`else
    logic unused_cfg;
    assign timeout_c  = 1'b0;
    assign unused_cfg = ^{grant_c, if_err_q, mem_err_q, 32'(TIMEOUT_CYCLES)};
    assign if_err     = 1'b0;
    assign mem_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            cmd_q       <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_err_q    <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            cmd_q       <= cmd_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_err_q    <= if_err_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign if_ready     = if_ready_q;
    assign if_rdata     = if_rdata_q;
    assign mem_ready    = mem_ready_q;
    assign mem_rdata    = mem_rdata_q;
    assign dram_rd_ctrl = cmd_q.rd_ctrl;
    assign dram_wr_ctrl = cmd_q.wr_ctrl;
    assign dram_addr    = cmd_q.addr;
    assign dram_din     = cmd_q.din;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: expected commands/responses queued, DRAM model and monitors compare.
module tb_dram_port_arbiter;

    localparam int BUDGET = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_ready;
    logic [63:0] if_rdata;
    logic        if_err;
    logic        mem_req = 1'b0;
    logic [63:0] mem_addr = '0;
    logic [2:0]  mem_rd_ctrl = '0;
    logic [2:0]  mem_wr_ctrl = '0;
    logic [63:0] mem_wdata = '0;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        mem_err;
    logic [2:0]  dram_rd_ctrl;
    logic [2:0]  dram_wr_ctrl;
    logic [63:0] dram_addr;
    logic [63:0] dram_din;
    logic [63:0] dram_dout = '0;
    logic        dram_done = 1'b0;

    always #5 clk = ~clk;

    dram_port_arbiter #(
        .IF_STARVE_LIMIT(4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ready    (if_ready),
        .if_rdata    (if_rdata),
        .if_err      (if_err),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rd_ctrl (mem_rd_ctrl),
        .mem_wr_ctrl (mem_wr_ctrl),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err),
        .dram_rd_ctrl(dram_rd_ctrl),
        .dram_wr_ctrl(dram_wr_ctrl),
        .dram_addr   (dram_addr),
        .dram_din    (dram_din),
        .dram_dout   (dram_dout),
        .dram_done   (dram_done)
    );

    typedef struct {
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic [63:0] addr;
        logic [63:0] din;
        bit          chk_din;
    } cmd_t;

    typedef struct {
        bit          is_mem;
        logic [63:0] rdata;
        logic        err;
    } rsp_t;

    cmd_t        cmd_q[$];
    rsp_t        rsp_q[$];
    int          delay_q[$];
    logic [63:0] dout_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_cmd(input logic [2:0] rd, input logic [2:0] wr, input logic [63:0] addr,
                              input logic [63:0] din, input bit chk_din, input int dly,
                              input logic [63:0] dout);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = addr; c.din = din; c.chk_din = chk_din;
        cmd_q.push_back(c);
        delay_q.push_back(dly);
        dout_q.push_back(dout);
    endtask

    task automatic expect_rsp(input bit is_mem, input logic [63:0] rdata, input logic err);
        rsp_t r;
        r.is_mem = is_mem; r.rdata = rdata; r.err = err;
        rsp_q.push_back(r);
    endtask

    // DRAM model: checks each new command, holds it, answers after the queued delay (-1 = never).
    logic        prev_v = 1'b0;
    logic        cmd_v;
    bit          active = 1'b0;
    int          cnt = 0;
    logic [63:0] cur_dout = '0;
    cmd_t        exp_c;
    logic [133:0] held;

    always @(negedge clk) begin
        dram_done = 1'b0;
        cmd_v = (dram_rd_ctrl != 3'd0) || (dram_wr_ctrl != 3'd0);
        if (cmd_v && !prev_v) begin
            if (cmd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_cmd: got rd=%0d wr=%0d addr=%h, required no command",
                         dram_rd_ctrl, dram_wr_ctrl, dram_addr);
                active = 1'b0;
            end else begin
                exp_c = cmd_q.pop_front();
                check("cmd_rd_ctrl", 64'(dram_rd_ctrl), 64'(exp_c.rd));
                check("cmd_wr_ctrl", 64'(dram_wr_ctrl), 64'(exp_c.wr));
                check("cmd_addr", dram_addr, exp_c.addr);
                if (exp_c.chk_din) check("cmd_din", dram_din, exp_c.din);
                cnt      = delay_q.pop_front();
                cur_dout = dout_q.pop_front();
                held     = {dram_rd_ctrl, dram_wr_ctrl, dram_addr, dram_din};
                active   = 1'b1;
            end
        end else if (cmd_v && active) begin
            check("cmd_hold", 64'({dram_rd_ctrl, dram_wr_ctrl, dram_addr, dram_din} == held), 64'd1);
        end
        if (!cmd_v) active = 1'b0;
        if (active) begin
            if (cnt == 0) begin
                dram_done = 1'b1;
                dram_dout = cur_dout;
                active    = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
            end
        end
        prev_v = cmd_v;
    end

    task automatic chk_rsp(input bit is_mem, input logic [63:0] rdata, input logic err);
        rsp_t r;
        if (rsp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ready: got ready on %s port, required none", is_mem ? "mem" : "if");
        end else begin
            r = rsp_q.pop_front();
            check("rsp_port_is_mem", 64'(is_mem), 64'(r.is_mem));
            check("rsp_rdata", rdata, r.rdata);
            check("rsp_err", 64'(err), 64'(r.err));
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (if_ready && mem_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL both_ready: got if_ready=1 mem_ready=1, required at most one");
        end
        if (if_ready) chk_rsp(1'b0, if_rdata, if_err);
        if (mem_ready) chk_rsp(1'b1, mem_rdata, mem_err);
    end

    task automatic if_request(input logic [63:0] a, output int lat);
        bit got;
        @(negedge clk);
        if_addr = a;
        if_req  = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < BUDGET) begin
            @(negedge clk);
            lat++;
            got = if_ready;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL if_ready_timeout: got no pulse in %0d cycles, required a pulse", lat);
        end
        if_req = 1'b0;
    endtask

    task automatic mem_request(input logic [63:0] a, input logic [2:0] rd, input logic [2:0] wr,
                               input logic [63:0] wd, output int lat);
        bit got;
        @(negedge clk);
        mem_addr    = a;
        mem_rd_ctrl = rd;
        mem_wr_ctrl = wr;
        mem_wdata   = wd;
        mem_req     = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < BUDGET) begin
            @(negedge clk);
            lat++;
            got = mem_ready;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL mem_ready_timeout: got no pulse in %0d cycles, required a pulse", lat);
        end
        mem_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "time limit exceeded");
    end

    initial begin
        int l_if, l_mem, wait_n;

        repeat (3) @(negedge clk);
        check("rst_if_ready", 64'(if_ready), 64'd0);
        check("rst_mem_ready", 64'(mem_ready), 64'd0);
        check("rst_dram_ctrl", 64'({dram_rd_ctrl, dram_wr_ctrl}), 64'd0);
        check("rst_dram_addr", dram_addr, 64'd0);
        check("rst_dram_din", dram_din, 64'd0);
        check("rst_rdata", if_rdata | mem_rdata, 64'd0);
        check("rst_err", 64'({if_err, mem_err}), 64'd0);
        rst = 1'b0;

        // IF-only fetch, done two cycles after the command
        expect_cmd(3'b010, 3'b000, 64'h1000, 64'h0, 1'b0, 2, 64'h0000_0013);
        expect_rsp(1'b0, 64'h0000_0013, 1'b0);
        if_request(64'h1000, l_if);
        check("if_latency", 64'(l_if), 64'd4);

        // MEM load, done in the first busy cycle
        expect_cmd(3'b011, 3'b000, 64'h2008, 64'h0, 1'b1, 0, 64'h1122_3344_5566_7788);
        expect_rsp(1'b1, 64'h1122_3344_5566_7788, 1'b0);
        mem_request(64'h2008, 3'b011, 3'b000, 64'h0, l_mem);
        check("mem_min_latency", 64'(l_mem), 64'd2);

        // MEM store: data held, rdata unchanged
        expect_cmd(3'b000, 3'b011, 64'h3000, 64'hDEAD_BEEF, 1'b1, 3, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_rsp(1'b1, 64'h1122_3344_5566_7788, 1'b0);
        mem_request(64'h3000, 3'b000, 3'b011, 64'hDEAD_BEEF, l_mem);

        // mem_req with no codes is never granted
        mem_addr = 64'h5000; mem_rd_ctrl = 3'b000; mem_wr_ctrl = 3'b000; mem_req = 1'b1;
        expect_cmd(3'b010, 3'b000, 64'h4000, 64'h0, 1'b0, 1, 64'h0010_0093);
        expect_rsp(1'b0, 64'h0010_0093, 1'b0);
        if_request(64'h4000, l_if);
        repeat (6) @(negedge clk);
        mem_req = 1'b0;

        // Starvation: MEM x4, IF, MEM
        for (int i = 0; i < 4; i++) begin
            expect_cmd(3'b011, 3'b000, 64'h6000 + 64'(i * 8), 64'h0, 1'b1, 1, 64'hA0 + 64'(i));
            expect_rsp(1'b1, 64'hA0 + 64'(i), 1'b0);
        end
        expect_cmd(3'b010, 3'b000, 64'h7000, 64'h0, 1'b0, 1, 64'h73);
        expect_rsp(1'b0, 64'h73, 1'b0);
        expect_cmd(3'b011, 3'b000, 64'h6020, 64'h0, 1'b1, 1, 64'hA4);
        expect_rsp(1'b1, 64'hA4, 1'b0);
        fork
            begin
                int lm;
                for (int i = 0; i < 5; i++) mem_request(64'h6000 + 64'(i * 8), 3'b011, 3'b000, 64'h0, lm);
            end
            begin
                int li;
                if_request(64'h7000, li);
            end
        join

        // Reset during BUSY_MEM drops the transaction
        expect_cmd(3'b011, 3'b000, 64'h8000, 64'h0, 1'b1, -1, 64'h0);
        @(negedge clk);
        mem_addr = 64'h8000; mem_rd_ctrl = 3'b011; mem_wr_ctrl = 3'b000; mem_wdata = 64'h0; mem_req = 1'b1;
        wait_n = 0;
        while (dram_rd_ctrl == 3'd0 && wait_n < BUDGET) begin
            @(negedge clk);
            wait_n++;
        end
        check("busy_mem_reached", 64'(dram_rd_ctrl), 64'd3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_ctrl", 64'({dram_rd_ctrl, dram_wr_ctrl}), 64'd0);
        check("rst_async_addr", dram_addr, 64'd0);
        check("rst_no_mem_ready", 64'(mem_ready), 64'd0);
        @(negedge clk);
        mem_req = 1'b0; mem_rd_ctrl = 3'b000;
        rst = 1'b0;
        expect_cmd(3'b010, 3'b000, 64'h9000, 64'h0, 1'b0, 0, 64'h0000_0013);
        expect_rsp(1'b0, 64'h0000_0013, 1'b0);
        if_request(64'h9000, l_if);
        check("post_rst_if_latency", 64'(l_if), 64'd2);

`ifdef DRAM_ARB_TIMEOUT_EN
        expect_cmd(3'b011, 3'b000, 64'hA008, 64'h0, 1'b1, 0, 64'h55);
        expect_rsp(1'b1, 64'h55, 1'b0);
        mem_request(64'hA008, 3'b011, 3'b000, 64'h0, l_mem);
        expect_cmd(3'b011, 3'b000, 64'hA000, 64'h0, 1'b1, -1, 64'h0);
        expect_rsp(1'b1, 64'h0, 1'b1);
        mem_request(64'hA000, 3'b011, 3'b000, 64'h0, l_mem);
        check("timeout_latency", 64'(l_mem), 64'd9);
`endif

        wait_n = 0;
        while (rsp_q.size() != 0 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        repeat (4) @(negedge clk);
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        check("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
